// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshake, flush-to-zero and exception flags.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1+EXP_W+MAN_W-1:0]   a,
  input  logic [1+EXP_W+MAN_W-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1+EXP_W+MAN_W-1:0]   result,
  output logic [3:0]                 flags
);
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned P_W   = 2 * MAN_W + 2;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam logic [E_W-1:0] E_BIAS = E_W'(BIAS);
  localparam logic [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {K_NORM, K_ZERO, K_INF, K_NAN} kind_t;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Unpack and classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             za, zb, ia, ib, na, nb;
  kind_t            kind_c;
  logic [E_W-1:0]   esum_c;

  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (&ea) && (ma == '0);
  assign ib = (&eb) && (mb == '0);
  assign na = (&ea) && (ma != '0);
  assign nb = (&eb) && (mb != '0);
  assign esum_c = E_W'(ea) + E_W'(eb) - E_BIAS;

  always_comb begin
    kind_c = K_NORM;
    if (na || nb || (ia && zb) || (ib && za)) kind_c = K_NAN;
    else if (ia || ib)                        kind_c = K_INF;
    else if (za || zb)                        kind_c = K_ZERO;
  end

  // Pipeline state
  logic             v1, v2, v3;
  logic             s1_sign, s2_sign, s3_sign;
  kind_t            s1_kind, s2_kind, s3_kind;
  logic [SIG_W-1:0] s1_siga, s1_sigb;
  logic [E_W-1:0]   s1_exp, s2_exp, s3_exp;
  logic [P_W-1:0]   s2_prod;
  logic [MAN_W-1:0] s3_man;
  logic             s3_inexact;

  // Normalise: bits below the leading one, aligned so the mantissa starts at the top
  logic [P_W-2:0]   pn;
  logic [MAN_W-1:0] man_c, man_r;
  logic             guard_c, sticky_c;
  logic [E_W-1:0]   exp_n, exp_r;

  assign pn       = s2_prod[P_W-1] ? s2_prod[P_W-2:0] : {s2_prod[P_W-3:0], 1'b0};
  assign man_c    = pn[P_W-2 -: MAN_W];
  assign guard_c  = pn[P_W-2-MAN_W];
  assign sticky_c = |pn[P_W-3-MAN_W:0];
  assign exp_n    = s2_exp + E_W'(s2_prod[P_W-1]);

`ifdef FP_MUL_RNE_EN
  logic             round_up;
  logic [MAN_W:0]   man_sum;
  assign round_up = guard_c && (sticky_c || man_c[0]);
  assign man_sum  = {1'b0, man_c} + SIG_W'(round_up);
  assign man_r    = man_sum[MAN_W-1:0];
  assign exp_r    = exp_n + E_W'(man_sum[MAN_W]);
`else
  assign man_r    = man_c;
  assign exp_r    = exp_n;
`endif

  // Special-case resolution and packing
  logic [W-1:0] res_c;
  logic [3:0]   flags_c;

  always_comb begin
    res_c   = '0;
    flags_c = '0;
    case (s3_kind)
      K_NAN: begin
        res_c   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        flags_c = 4'b1000;
      end
      K_INF:  res_c = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      K_ZERO: res_c = {s3_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if ($signed(s3_exp) >= $signed(E_MAX)) begin
          res_c   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_c = 4'b0101;
        end else if ($signed(s3_exp) <= 0) begin
          res_c   = {s3_sign, {(EXP_W+MAN_W){1'b0}}};
          flags_c = 4'b0011;
        end else begin
          res_c   = {s3_sign, s3_exp[EXP_W-1:0], s3_man};
          flags_c = {3'b000, s3_inexact};
        end
      end
    endcase
  end

  // Valid bits and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        result <= res_c;
        flags  <= flags_c;
      end
    end
  end

  // Datapath registers; contents only matter when the matching valid is set
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign    <= a[W-1] ^ b[W-1];
      s1_kind    <= kind_c;
      s1_siga    <= {1'b1, ma};
      s1_sigb    <= {1'b1, mb};
      s1_exp     <= esum_c;
      s2_sign    <= s1_sign;
      s2_kind    <= s1_kind;
      s2_prod    <= P_W'(s1_siga) * P_W'(s1_sigb);
      s2_exp     <= s1_exp;
      s3_sign    <= s2_sign;
      s3_kind    <= s2_kind;
      s3_exp     <= exp_r;
      s3_man     <= man_r;
      s3_inexact <= guard_c | sticky_c;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (default widths); honours FP_MUL_RNE_EN like the design.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  logic [35:0] q[$];
  logic [35:0] got_q[$];
  int total = 0, bad = 0, cyc = 0, n_out = 0, last_acc = 0, last_drain = 0;
  logic        prev_stall = 1'b0;
  logic [35:0] prev_out = '0;
  logic        acc;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Independent reference: integer product, remainder-vs-half rounding
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, zx, zy, ix, iy, nx, ny, inex;
    int ex, ey, e, sh;
    longint unsigned p, rem, half, man;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC00000};
    if (ix || iy) return {4'b0000, s, 8'hFF, 23'h0};
    if (zx || zy) return {4'b0000, s, 31'h0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    man  = (p >> sh) & 64'h7FFFFF;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    inex = (rem != 0);
`ifdef FP_MUL_RNE_EN
    if (rem > half || (rem == half && man[0])) man++;
    if (man == 64'h800000) begin man = 0; e++; end
`endif
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
    if (e <= 0)   return {4'b0011, s, 31'h0};
    return {3'b000, inex, s, 8'(e), 23'(man)};
  endfunction

  // One cycle: drive at negedge, sample settled handshake, update scoreboard
  task automatic step(input logic r, input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic ordy, output logic accepted);
    logic [35:0] e;
    @(negedge clk);
    rst = r; in_valid = iv; a = ia; b = ib; out_ready = ordy;
    #1;
    cyc++;
    accepted = 1'b0;
    if (r) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {flags, result}, prev_out);
      if (out_valid && !out_ready) chk("in_ready_stall", 36'(in_ready), 36'd0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stale", 36'(out_valid), 36'd0);
        else begin
          e = q.pop_front();
          chk("res", {flags, result}, e);
          got_q.push_back({flags, result});
          n_out++;
          last_drain = cyc;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_mul(a, b));
        accepted = 1'b1;
        last_acc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {flags, result};
    end
  endtask

  task automatic drain_to(input int want);
    logic ac;
    for (int i = 0; i < 50 && n_out < want; i++) step(1'b0, 1'b0, '0, '0, 1'b1, ac);
    chk("drain_cnt", 36'(n_out), 36'(want));
  endtask

  function automatic logic [31:0] rnd_normal();
    return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  initial begin
    logic [31:0] sa[4];
    logic [31:0] sb[4];
    logic [35:0] se[4];
    logic [31:0] oa, ob;
    int base, issued;

    step(1'b1, 1'b0, '0, '0, 1'b1, acc);
    step(1'b1, 1'b0, '0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_result", 36'(result), 36'd0);
    chk("rst_flags", 36'(flags), 36'd0);
    chk("rst_in_ready", 36'(in_ready), 36'd1);

    // Basic product and latency
    base = n_out;
    step(1'b0, 1'b1, 32'h3FC00000, 32'h40000000, 1'b1, acc);
    drain_to(base + 1);
    chk("basic", got_q[got_q.size()-1], {4'h0, 32'h40400000});
    chk("latency", 36'(last_drain - last_acc), 36'd4);

    // Rounding
    base = n_out;
    step(1'b0, 1'b1, 32'h3FC00000, 32'h3F800001, 1'b1, acc);
    drain_to(base + 1);
`ifdef FP_MUL_RNE_EN
    chk("round", got_q[got_q.size()-1], {4'h1, 32'h3FC00002});
`else
    chk("round", got_q[got_q.size()-1], {4'h1, 32'h3FC00001});
`endif

    // Specials back-to-back
    sa = '{32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000};
    sb = '{32'h00000000, 32'h40000000, 32'h7F000000, 32'h00800000};
    se = '{{4'h8, 32'h7FC00000}, {4'h0, 32'hFF800000}, {4'h5, 32'h7F800000}, {4'h3, 32'h00000000}};
    base = n_out;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, sa[i], sb[i], 1'b1, acc);
    drain_to(base + 4);
    for (int i = 0; i < 4; i++) chk("special", got_q[base + i], se[i]);

    // Backpressure: out_ready low for cycles 4..9
    base = n_out;
    issued = 0;
    oa = rnd_normal();
    ob = rnd_normal();
    for (int k = 1; k <= 60; k++) begin
      if (issued >= 6 && n_out >= base + 6) break;
      step(1'b0, issued < 6, oa, ob, !(k >= 4 && k <= 9), acc);
      if (acc) begin
        issued++;
        oa = rnd_normal();
        ob = rnd_normal();
      end
    end
    chk("bp_count", 36'(n_out - base), 36'd6);

    // Reset with three operations in flight
    base = n_out;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_normal(), rnd_normal(), 1'b1, acc);
    step(1'b1, 1'b0, '0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    chk("rst_flush_valid", 36'(out_valid), 36'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, acc);
    chk("rst_flush_count", 36'(n_out), 36'(base));
    step(1'b0, 1'b1, 32'h40000000, 32'hC0400000, 1'b1, acc);
    drain_to(base + 1);
    chk("rst_latency", 36'(last_drain - last_acc), 36'd4);
    chk("rst_next", got_q[got_q.size()-1], {4'h0, 32'hC0C00000});

    // Random traffic with random backpressure and arbitrary bit patterns
    for (int i = 0; i < 300; i++) begin
      oa = ($urandom_range(0, 3) == 0) ? 32'($urandom) : rnd_normal();
      ob = ($urandom_range(0, 3) == 0) ? 32'($urandom) : rnd_normal();
      step(1'b0, 1'($urandom_range(0, 3) != 0), oa, ob, 1'($urandom_range(0, 2) != 0), acc);
    end
    drain_to(n_out + q.size());
    chk("queue_empty", 36'(q.size()), 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
